fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the multi-cycle datapath and control unit. It owns the fetch handshake with instruction memory and latches the instruction register (IR) cleanly, so the datapath never derives IR combinationally from memory output. On request from the control unit it:
- reads the word at the current PC,
- waits for the memory's read-valid,
- registers the returned word,
- pulses ir_valid so the control unit can leave its fetch state.
It also detects misaligned PCs and memory timeouts.

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch handshake bundle between control unit, instruction memory and fetch_unit.
//   fetch_req/pc_in/flush : fetch request from control unit / pc unit
//   mem_rd_en/mem_addr    : read strobe and word address to instruction memory
//   mem_rdata/mem_rvalid  : read response from instruction memory
//   ir/ir_valid/busy/fetch_err : fetch results and status
// master: environment side (control unit + memory); slave: fetch_unit.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              fetch_req;
    logic [31:0]       pc_in;
    logic              flush;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;
    logic [31:0]       ir;
    logic              ir_valid;
    logic              busy;
    logic              fetch_err;

    modport master (
        output fetch_req, pc_in, flush, mem_rdata, mem_rvalid,
        input  mem_rd_en, mem_addr, ir, ir_valid, busy, fetch_err
    );

    modport slave (
        input  fetch_req, pc_in, flush, mem_rdata, mem_rvalid,
        output mem_rd_en, mem_addr, ir, ir_valid, busy, fetch_err
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one memory read per request, waits for the
// read-valid, registers the returned word into ir and pulses ir_valid.
// Misaligned PCs and memory timeouts park the unit in a sticky error state
// that only flush clears.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        fetch_unit_if.slave (request, memory and result signals)
module fetch_unit #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.slave  bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [31:0]       ir_q, ir_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;

    // PC bits above the memory window are intentionally ignored (address wraps).
    logic unused_pc_bits;
    assign unused_pc_bits = ^bus.pc_in[31:ADDR_W+2];

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            addr_q <= '0;
            ir_q   <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
            ir_q   <= ir_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    // Next-state logic; flush outranks rvalid and timeout
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        ir_nxt    = ir_q;
        cnt_nxt   = cnt_q;
        case (state)
            S_IDLE: begin
                if (bus.fetch_req && !bus.flush) begin
                    if (bus.pc_in[1:0] != 2'b00) begin
                        state_nxt = S_ERR;
                    end else begin
                        addr_nxt  = bus.pc_in[ADDR_W+1:2];
                        state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_nxt   = '0;
                state_nxt = bus.flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (bus.flush) begin
                    state_nxt = S_IDLE;
                end else if (bus.mem_rvalid) begin
                    ir_nxt    = bus.mem_rdata;
                    state_nxt = S_DONE;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    // rvalid already had its chance in this last WAIT cycle
                    state_nxt = S_ERR;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (bus.flush) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs come straight from registers or the state decode
    assign bus.mem_rd_en = (state == S_REQ);
    assign bus.mem_addr  = addr_q;
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = (state == S_DONE);
    assign bus.busy      = (state == S_REQ) || (state == S_WAIT) || (state == S_DONE);
    assign bus.fetch_err = (state == S_ERR);
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned MAX_WAIT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_unit #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];
    logic [31:0] last_ir = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          lat;    // WAIT cycle carrying rvalid; 0 = never (timeout)
        logic [31:0] addr;
        bit          mis;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every ir_valid pulse must match the oldest pushed response
    always @(negedge clk) begin
        if (!rst && bus.ir_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ir_valid: got ir %h expected no pulse at %0t", bus.ir, $time);
            end else begin
                chk("ir_on_valid", bus.ir, sb.pop_front());
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        bus.fetch_req = 1'b1;
        bus.pc_in     = v.pc;
        @(negedge clk);
        bus.fetch_req = 1'b0;
        if (v.mis) begin
            chk("mis_rd_en", bus.mem_rd_en, 0);
            chk("mis_err", bus.fetch_err, 1);
            bus.fetch_req = 1'b1;
            bus.pc_in     = 32'h0;
            @(negedge clk);
            chk("err_held", bus.fetch_err, 1);
            chk("err_req_ignored", bus.mem_rd_en, 0);
            chk("err_not_busy", bus.busy, 0);
            bus.fetch_req = 1'b0;
            bus.flush     = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
            chk("flush_clears_err", bus.fetch_err, 0);
            chk("flush_idle_busy", bus.busy, 0);
            return;
        end
        chk("req_rd_en", bus.mem_rd_en, 1);
        chk("req_addr", bus.mem_addr, v.addr);
        chk("req_busy", bus.busy, 1);
        n = (v.lat == 0) ? int'(MAX_WAIT) : v.lat;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk("wait_rd_en", bus.mem_rd_en, 0);
            chk("wait_busy", bus.busy, 1);
            chk("wait_err", bus.fetch_err, 0);
            if (k == v.lat) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = v.data;
                sb.push_back(v.data);
                last_ir = v.data;
            end
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        if (v.lat != 0) begin
            chk("done_ir_valid", bus.ir_valid, 1);
            chk("done_busy", bus.busy, 1);
            @(negedge clk);
            chk("after_busy", bus.busy, 0);
            chk("after_ir_valid", bus.ir_valid, 0);
        end else begin
            chk("timeout_err", bus.fetch_err, 1);
            chk("timeout_busy", bus.busy, 0);
            chk("timeout_ir_kept", bus.ir, last_ir);
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
            chk("timeout_flush", bus.fetch_err, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fetch_req  = 1'b0;
        bus.pc_in      = 32'h0;
        bus.flush      = 1'b0;
        bus.mem_rdata  = 32'h0;
        bus.mem_rvalid = 1'b0;

        vecs[0] = '{pc: 32'h0000_000C, data: 32'h8C22_0004, lat: 1,  addr: 32'd3,  mis: 1'b0};
        vecs[1] = '{pc: 32'h0000_0104, data: 32'h1111_1111, lat: 2,  addr: 32'd1,  mis: 1'b0};
        vecs[2] = '{pc: 32'h0000_0006, data: 32'h0,         lat: 0,  addr: 32'd0,  mis: 1'b1};
        vecs[3] = '{pc: 32'h0000_00FC, data: 32'hA5A5_5A5A, lat: 15, addr: 32'd63, mis: 1'b0};
        vecs[4] = '{pc: 32'h0000_0010, data: 32'h0,         lat: 0,  addr: 32'd4,  mis: 1'b0};
        vecs[5] = '{pc: 32'h0000_000C, data: 32'h8C22_0004, lat: 1,  addr: 32'd3,  mis: 1'b0};

        #1;
        chk("rst_ir", bus.ir, 0);
        chk("rst_ir_valid", bus.ir_valid, 0);
        chk("rst_rd_en", bus.mem_rd_en, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.fetch_err, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // flush together with rvalid in WAIT: response dropped, ir kept
        @(negedge clk);
        bus.fetch_req = 1'b1;
        bus.pc_in     = 32'h0000_0020;
        @(negedge clk);
        bus.fetch_req = 1'b0;
        @(negedge clk);
        bus.flush      = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        bus.flush      = 1'b0;
        bus.mem_rvalid = 1'b0;
        chk("flush_wait_busy", bus.busy, 0);
        chk("flush_wait_ir", bus.ir, 32'h8C22_0004);
        chk("flush_wait_ir_valid", bus.ir_valid, 0);

        // flush in REQ aborts before WAIT
        bus.fetch_req = 1'b1;
        bus.pc_in     = 32'h0000_0024;
        @(negedge clk);
        bus.fetch_req = 1'b0;
        bus.flush     = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_req_busy", bus.busy, 0);

        // fetch_req held high: one fetch every 4 cycles, wrapped address
        bus.fetch_req = 1'b1;
        bus.pc_in     = 32'h0000_0104;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk("held_rd_en", bus.mem_rd_en, ((i % 4) == 1) ? 32'd1 : 32'd0);
            if ((i % 4) == 1) chk("held_addr", bus.mem_addr, 1);
            bus.mem_rvalid = 1'b0;
            if ((i % 4) == 2) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hC0DE_0000 + 32'(i);
                sb.push_back(32'hC0DE_0000 + 32'(i));
                last_ir = 32'hC0DE_0000 + 32'(i);
            end
            if (i == 12) bus.fetch_req = 1'b0;
        end

        // spurious rvalid while idle
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        chk("spurious_ir", bus.ir, last_ir);
        chk("spurious_busy", bus.busy, 0);

        // asynchronous reset in WAIT, later rvalid ignored
        bus.fetch_req = 1'b1;
        bus.pc_in     = 32'h0000_0008;
        @(negedge clk);
        bus.fetch_req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ir", bus.ir, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_addr", bus.mem_addr, 0);
        chk("arst_rd_en", bus.mem_rd_en, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        chk("arst_late_rvalid_ir", bus.ir, 0);
        chk("arst_late_ir_valid", bus.ir_valid, 0);
        @(negedge clk);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
